tlul_mem_slave: RTL
===================

# tlul_mem_slave

Parametrised TileLink-UL memory slave: Get, PutFullData and PutPartialData on the A channel, an internal byte-maskable word memory, and a response FIFO so several requests can be outstanding before the D channel drains. It is the general successor to the fixed-pattern Get-only slave and is the default TL-UL endpoint for bus-level benches and SoC integration.

## Interface
- DW, 32, data width in bits; multiple of 8, at most 64
- AW, 32, address width
- SW, 3, source ID width
- DEPTH, 256, memory depth in DW-bit words
- RSP_DEPTH, 2, response FIFO entries; at least 1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  request valid
- a_ready  out  1  request ready
- a_opcode  in  3  0 = PutFullData, 1 = PutPartialData, 4 = Get
- a_param  in  3  ignored
- a_size  in  $clog2(DW/8)+1  log2 of bytes
- a_mask  in  DW/8  byte enables
- a_address  in  AW  byte address
- a_data  in  DW  write data
- a_source  in  SW  source ID
- d_valid  out  1  response valid
- d_ready  in  1  response ready
- d_opcode  out  3  0 = AccessAck, 1 = AccessAckData
- d_param  out  3  constant 0
- d_size  out  $clog2(DW/8)+1  echoes a_size
- d_source  out  SW  echoes a_source
- d_sink  out  2  constant 0
- d_data  out  DW  read data; 0 for Put responses and for errors
- d_error  out  1  request was rejected

## Operation
- Accept: a request is taken when a_valid && a_ready. a_ready = !fifo_full, with no same-cycle pass-through when the FIFO is full.
- Word index = a_address[AW-1:$clog2(DW/8)].
- Error conditions. The request gets d_error=1, has no memory side effect, and returns d_data=0 if any of these hold:
  - index >= DEPTH
  - a_address is not aligned to 2^a_size
  - a_size > $clog2(DW/8)
  - the opcode is not 0, 1 or 4
  - PutFullData with a_mask not all ones
  - a_mask == 0
- The error response opcode follows the request: AccessAckData for Get, AccessAck otherwise. An unknown opcode returns AccessAck.
- Get: the memory word is read at acceptance, and bytes with a_mask=0 are zeroed. The result is pushed into the FIFO.
- Put: at acceptance, bytes with a_mask=1 are written. AccessAck is pushed into the FIFO.
- Read-after-write: a Get accepted in the cycle after a Put sees the Put's data.
- Responses return strictly in acceptance order.
- FIFO:
  - d_valid = !fifo_empty.
  - Pop when d_valid && d_ready.
  - Push and pop in the same cycle keep the occupancy unchanged. This is legal when the FIFO is full only if no push occurs, because a_ready=0.
  - Read and write pointers wrap modulo RSP_DEPTH.
  - The occupancy counter is $clog2(RSP_DEPTH+1) bits wide.
- D outputs stay stable while d_valid && !d_ready.

## Timing
- Reset values: a_ready=1, d_valid=0. d_opcode, d_param, d_size, d_source, d_sink, d_data and d_error are all 0. FIFO is empty and pointers are 0. Memory is all zeros.
- Latency: the response is valid on the cycle after acceptance (1 cycle).
- Throughput: 1 request/cycle while d_ready=1 continuously.
- Reset mid-operation: asserting rst_n low immediately clears pending responses and returns the outputs to their reset values. Memory is also cleared.
- A write whose acceptance edge coincides with reset assertion is lost.

## Structure
- Package tlul_pkg holds:
  - enum a_op_e (PutFullData=0, PutPartialData=1, Get=4)
  - enum d_op_e (AccessAck=0, AccessAckData=1)
  - a parametrised response struct {opcode, size, source, data, error}
- Sub-module tlul_rsp_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH, and full/empty/count outputs. It stores the packed response struct.
- The top level contains the decode/error check, the memory array with byte-lane write and masked read, and the FIFO instance.

## Test plan
- Reset, then PutFull to 0x10 (data 0xDEADBEEF, mask 0xF, source 2), then Get 0x10 with mask 0x3:
  - Put → AccessAck, error 0, source 2.
  - Get → AccessAckData, data 0x0000BEEF.
- PutPartial to 0x10 (mask 0x4, data 0x00AA0000), then Get with mask 0xF → data 0xDEAABEEF.
- Hold d_ready=0 and issue 3 Gets (sources 0, 1, 2) with RSP_DEPTH=2:
  - a_ready drops after the 2nd acceptance.
  - After d_ready=1, responses come out in order 0, 1, 2, with d outputs stable while stalled.
- Errors:
  - Get at 0x400 (DEPTH=256) → d_error=1, data 0.
  - Get at 0x2 with size 2 → error.
  - PutFull with mask 0x7 → error, and a subsequent Get shows memory unchanged.
  - Opcode 2 → AccessAck with error.
- Back-to-back Put/Get every cycle with d_ready=1: one response per cycle, latency 1, Get returns the just-written data.
- Assert rst_n with 2 responses pending → d_valid=0 immediately, a_ready=1, and a Get to any address returns 0.

Source files
------------

// File: rtl/tlul_pkg.sv
// Shared TL-UL opcode enums and request-decode helper for the memory slave.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } d_op_e;

  function automatic logic known_op(logic [2:0] op);
    return (op == PutFullData) || (op == PutPartialData) || (op == Get);
  endfunction

endpackage

// File: rtl/tlul_rsp_fifo.sv
// Generic synchronous FIFO holding packed D-channel responses; output reads 0 when empty.
module tlul_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= inc(wptr);
      if (pop_ok)  rptr <= inc(rptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/tlul_mem_slave.sv
// TL-UL memory slave: request decode/error check, byte-lane memory, in-order response FIFO.
module tlul_mem_slave
  import tlul_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int SW        = 3,
  parameter int DEPTH     = 256,
  parameter int RSP_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [2:0]                a_opcode,
  input  logic [2:0]                a_param,
  input  logic [$clog2(DW/8):0]     a_size,
  input  logic [DW/8-1:0]           a_mask,
  input  logic [AW-1:0]             a_address,
  input  logic [DW-1:0]             a_data,
  input  logic [SW-1:0]             a_source,
  output logic                      d_valid,
  input  logic                      d_ready,
  output logic [2:0]                d_opcode,
  output logic [2:0]                d_param,
  output logic [$clog2(DW/8):0]     d_size,
  output logic [SW-1:0]             d_source,
  output logic [1:0]                d_sink,
  output logic [DW-1:0]             d_data,
  output logic                      d_error
);

  localparam int NB  = DW/8;
  localparam int OFF = $clog2(NB);
  localparam int SZW = OFF+1;
  localparam int IW  = AW-OFF;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(RSP_DEPTH+1);

  typedef struct packed {
    d_op_e          opcode;
    logic [SZW-1:0] size;
    logic [SW-1:0]  source;
    logic [DW-1:0]  data;
    logic           error;
  } rsp_t;

  logic [DW-1:0]  mem [DEPTH];
  logic [IW-1:0]  idx;
  logic [MW-1:0]  widx;
  logic [OFF-1:0] align_mask;
  logic [DW-1:0]  bmask, rdata;
  logic           is_get, is_full, is_put, err;
  logic           push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]  unused_count;
  logic           unused_param;
  rsp_t           rsp_d, rsp_q;

  assign unused_param = ^a_param;
  assign idx  = a_address[AW-1:OFF];
  assign widx = idx[MW-1:0];

  for (genvar b = 0; b < NB; b++) begin : g_bmask
    assign bmask[b*8 +: 8] = {8{a_mask[b]}};
  end

  assign is_get     = (a_opcode == Get);
  assign is_full    = (a_opcode == PutFullData);
  assign is_put     = is_full || (a_opcode == PutPartialData);
  assign align_mask = OFF'((32'd1 << a_size) - 32'd1);

  assign err = (idx >= IW'(DEPTH))
            || (a_size > SZW'(OFF))
            || (|(a_address[OFF-1:0] & align_mask))
            || !known_op(a_opcode)
            || (a_mask == '0)
            || (is_full && !(&a_mask));

  // Out-of-range indices alias into the array here, but err zeroes the data.
  assign rdata = mem[widx] & bmask;

  always_comb begin
    rsp_d        = '0;
    rsp_d.opcode = is_get ? AccessAckData : AccessAck;
    rsp_d.size   = a_size;
    rsp_d.source = a_source;
    rsp_d.data   = (is_get && !err) ? rdata : '0;
    rsp_d.error  = err;
  end

  assign a_ready = !fifo_full;
  assign push    = a_valid && a_ready;
  assign pop     = d_valid && d_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && is_put && !err) begin
      for (int b = 0; b < NB; b++)
        if (a_mask[b]) mem[widx][b*8 +: 8] <= a_data[b*8 +: 8];
    end
  end

  tlul_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (rsp_d),
    .pop   (pop),
    .dout  (rsp_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_count)
  );

  assign d_valid  = !fifo_empty;
  assign d_opcode = rsp_q.opcode;
  assign d_param  = '0;
  assign d_size   = rsp_q.size;
  assign d_source = rsp_q.source;
  assign d_sink   = '0;
  assign d_data   = rsp_q.data;
  assign d_error  = rsp_q.error;

endmodule
